// File: rtl/ll_pkg.sv
// ============================================================================
//  Module      : ll_pkg
//  Description : Shared types and constants for the lander BCD state update.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ll_pkg;

    typedef logic [15:0] bcd4_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLAMP  = 3'd1,
        ST_ALT    = 3'd2,
        ST_VELT   = 3'd3,
        ST_VELG   = 3'd4,
        ST_FUEL   = 3'd5,
        ST_COMMIT = 3'd6
    } ll_upd_state_t;

    localparam bcd4_t BCD_NEG_MIN    = 16'h5000;
    localparam bcd4_t BCD_POS_MAX    = 16'h4999;
    localparam bcd4_t LL_GRAVITY_DEF = 16'h0005;
    localparam bcd4_t LL_ALT_INIT    = 16'h4500;
    localparam bcd4_t LL_VEL_INIT    = 16'h0000;
    localparam bcd4_t LL_FUEL_INIT   = 16'h0800;

    // 10's complement sign class: a most-significant digit of 5..9 is negative
    function automatic logic bcd_is_neg(input logic [3:0] ms_digit);
        return ms_digit >= 4'd5;
    endfunction

    function automatic logic [3:0] bcd_digit(input bcd4_t x, input logic [1:0] idx);
        return x[{idx, 2'b00} +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_addsub.sv
// ============================================================================
//  Module      : bcd_digit_addsub
//  Description : Single BCD digit adder/subtractor with decimal carry/borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       op,    // 0 = a + b + cin, 1 = a - b - cin
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_raw;

    always_comb begin
        w_raw = 5'd0;
        s     = 4'd0;
        cout  = 1'b0;
        if (op) begin
            w_raw = {1'b0, a} - {1'b0, b} - {4'd0, cin};
            cout  = w_raw[4];
            s     = cout ? (w_raw[3:0] + 4'd10) : w_raw[3:0];
        end else begin
            w_raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
            cout  = (w_raw > 5'd9);
            s     = cout ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ll_state_update.sv
// ============================================================================
//  Module      : ll_state_update
//  Description : Digit-serial BCD integrator for altitude, velocity and fuel,
//                sharing one BCD digit adder. Optional LL_VEL_SAT_EN macro
//                enables velocity saturation on signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ll_state_update
    import ll_pkg::*;
#(
    parameter bcd4_t GRAVITY   = LL_GRAVITY_DEF,
    parameter bcd4_t ALT_INIT  = LL_ALT_INIT,
    parameter bcd4_t VEL_INIT  = LL_VEL_INIT,
    parameter bcd4_t FUEL_INIT = LL_FUEL_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        wen,
    input  logic [15:0] thrust,
    output logic [15:0] alt,
    output logic [15:0] vel,
    output logic [15:0] fuel,
    output logic [15:0] thrust_eff,
    output logic        busy,
    output logic        done
);

    ll_upd_state_t r_state;
    ll_upd_state_t w_state_nxt;
    logic [1:0]    r_dig;
    logic          r_cy;
    logic          r_done;
    bcd4_t         r_alt, r_vel, r_fuel, r_te_eff;
    bcd4_t         r_te, r_alt_n, r_vel_n, r_fuel_n;

    logic          w_last, w_is_phase, w_commit;
    logic [3:0]    w_a, w_b, w_s;
    logic          w_op, w_cin, w_cout;
    bcd4_t         w_te_thr, w_te_clamp;
    logic          w_vel_ov;
    bcd4_t         w_vel_sat;

    assign w_last     = (r_dig == 2'd3);
    assign w_is_phase = (r_state == ST_ALT)  || (r_state == ST_VELT) ||
                        (r_state == ST_VELG) || (r_state == ST_FUEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dig   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_dig   <= w_is_phase ? (r_dig + 2'd1) : 2'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE:   if (tick && wen) w_state_nxt = ST_CLAMP;
            ST_CLAMP:  w_state_nxt = ST_ALT;
            ST_ALT:    if (w_last) w_state_nxt = ST_VELT;
            ST_VELT:   if (w_last) w_state_nxt = ST_VELG;
            ST_VELG:   if (w_last) w_state_nxt = ST_FUEL;
            ST_FUEL:   if (w_last) w_state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                w_commit    = wen;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand routing for the shared digit adder
    always_comb begin
        w_a  = 4'd0;
        w_b  = 4'd0;
        w_op = 1'b0;
        case (r_state)
            ST_ALT: begin
                w_a = bcd_digit(r_alt, r_dig);
                w_b = bcd_digit(r_vel, r_dig);
            end
            ST_VELT: begin
                w_a = bcd_digit(r_vel, r_dig);
                w_b = bcd_digit(r_te, r_dig);
            end
            ST_VELG: begin
                w_a  = bcd_digit(r_vel_n, r_dig);
                w_b  = bcd_digit(GRAVITY, r_dig);
                w_op = 1'b1;
            end
            ST_FUEL: begin
                w_a  = bcd_digit(r_fuel, r_dig);
                w_b  = bcd_digit(r_te, r_dig);
                w_op = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cin = (r_dig == 2'd0) ? 1'b0 : r_cy;

    bcd_digit_addsub u_addsub (
        .a    (w_a),
        .b    (w_b),
        .op   (w_op),
        .cin  (w_cin),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_te_thr   = bcd_is_neg(thrust[15:12]) ? 16'h0000 : thrust;
    assign w_te_clamp = (w_te_thr > r_fuel) ? r_fuel : w_te_thr;

`ifdef LL_VEL_SAT_EN
    logic w_sa, w_sb, w_sr;

    // Overflow judged on the last digit from operand/result sign classes
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        if (r_state == ST_VELG) begin
            w_sa = bcd_is_neg(r_vel_n[15:12]);
            w_sb = bcd_is_neg(GRAVITY[15:12]);
        end else begin
            w_sa = bcd_is_neg(r_vel[15:12]);
            w_sb = bcd_is_neg(r_te[15:12]);
        end
        w_sr     = bcd_is_neg(w_s);
        w_vel_ov = w_last && ((r_state == ST_VELT) || (r_state == ST_VELG)) &&
                   (w_op ? (w_sa != w_sb) : (w_sa == w_sb)) && (w_sr != w_sa);
    end

    assign w_vel_sat = w_sa ? BCD_NEG_MIN : BCD_POS_MAX;
`else
    assign w_vel_ov  = 1'b0;
    assign w_vel_sat = 16'h0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alt    <= ALT_INIT;
            r_vel    <= VEL_INIT;
            r_fuel   <= FUEL_INIT;
            r_te_eff <= 16'h0000;
            r_te     <= 16'h0000;
            r_alt_n  <= 16'h0000;
            r_vel_n  <= 16'h0000;
            r_fuel_n <= 16'h0000;
            r_cy     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLAMP: r_te <= w_te_clamp;
                ST_ALT:   r_alt_n[{r_dig, 2'b00} +: 4] <= w_s;
                ST_VELT, ST_VELG: begin
                    if (w_vel_ov) r_vel_n <= w_vel_sat;
                    else          r_vel_n[{r_dig, 2'b00} +: 4] <= w_s;
                end
                ST_FUEL:  r_fuel_n[{r_dig, 2'b00} +: 4] <= w_s;
                default: ;
            endcase
            if (w_is_phase) r_cy <= w_cout;
            if (w_commit) begin
                r_alt    <= r_alt_n;
                r_vel    <= r_vel_n;
                r_fuel   <= r_fuel_n;
                r_te_eff <= r_te;
            end
            r_done <= w_commit;
        end
    end

    assign alt        = r_alt;
    assign vel        = r_vel;
    assign fuel       = r_fuel;
    assign thrust_eff = r_te_eff;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ll_state_update.sv
// ============================================================================
//  Module      : tb_ll_state_update
//  Description : Self-checking bench for ll_state_update (vector table, corner
//                sequences and randomized steps against an integer model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ll_state_update;
    import ll_pkg::*;

    logic        clk = 1'b0;
    logic        rst, tick, wen;
    logic [15:0] thrust;
    logic [15:0] alt, vel, fuel, thrust_eff;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    int m_alt, m_vel, m_fuel, m_te;
    localparam int G = 5;

    typedef struct {
        logic [15:0] thr;
        logic [15:0] alt;
        logic [15:0] vel;
        logic [15:0] fuel;
        logic [15:0] te;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    ll_state_update dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .wen        (wen),
        .thrust     (thrust),
        .alt        (alt),
        .vel        (vel),
        .fuel       (fuel),
        .thrust_eff (thrust_eff),
        .busy       (busy),
        .done       (done)
    );

    function automatic int bcd2int(input logic [15:0] x);
        return int'(x[15:12]) * 1000 + int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic int to_signed(input int v);
        return (v >= 5000) ? v - 10000 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_alt = 4500; m_vel = 0; m_fuel = 800; m_te = 0;
    endtask

    // One physics step computed with whole-number arithmetic mod 10000
    task automatic model_step(input logic [15:0] t);
        int te, sv;
        logic [15:0] tt;
        tt = t;
        te = (tt[15:12] >= 4'd5) ? 0 : bcd2int(tt);
        if (te > m_fuel) te = m_fuel;
        m_alt = (m_alt + m_vel) % 10000;
`ifdef LL_VEL_SAT_EN
        sv = to_signed(m_vel) + te;
        if (sv > 4999) sv = 4999;
        sv = sv - G;
        if (sv < -5000) sv = -5000;
        m_vel = (sv + 10000) % 10000;
`else
        sv = 0;
        m_vel = (m_vel + te + 10000 - G) % 10000;
`endif
        m_fuel = m_fuel - te;
        m_te   = te;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_alt"},  alt,        int2bcd(m_alt));
        chk({tag, "_vel"},  vel,        int2bcd(m_vel));
        chk({tag, "_fuel"}, fuel,       int2bcd(m_fuel));
        chk({tag, "_te"},   thrust_eff, int2bcd(m_te));
    endtask

    task automatic start_step(input logic [15:0] t);
        @(negedge clk);
        thrust = t; tick = 1'b1; wen = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        lat = seen ? n : -1;
    endtask

    task automatic run_step(input logic [15:0] t);
        int lat;
        start_step(t);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("latency", lat, 18);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        model_step(t);
    endtask

    task automatic count_done(input int cyc, output int nd);
        nd = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    initial begin
        int          lat, nd;
        logic [15:0] s_alt, s_vel, s_fuel, s_te, t, exp6;

        tbl[0] = '{16'h0000, 16'h4500, 16'h9995, 16'h0800, 16'h0000};
        tbl[1] = '{16'h0000, 16'h4495, 16'h9990, 16'h0800, 16'h0000};
        tbl[2] = '{16'h0010, 16'h4485, 16'h9995, 16'h0790, 16'h0010};
        tbl[3] = '{16'h5000, 16'h4480, 16'h9990, 16'h0790, 16'h0000};
        tbl[4] = '{16'h0775, 16'h4470, 16'h0760, 16'h0015, 16'h0775};
        tbl[5] = '{16'h0020, 16'h5230, 16'h0770, 16'h0000, 16'h0015};
        tbl[6] = '{16'h0020, 16'h6000, 16'h0765, 16'h0000, 16'h0000};

        rst = 1'b1; tick = 1'b0; wen = 1'b1; thrust = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_alt",  alt,  16'h4500);
        chk("rst_vel",  vel,  16'h0000);
        chk("rst_fuel", fuel, 16'h0800);
        chk("rst_te",   thrust_eff, 16'h0000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_step(tbl[i].thr);
            chk("tbl_alt",  alt,        tbl[i].alt);
            chk("tbl_vel",  vel,        tbl[i].vel);
            chk("tbl_fuel", fuel,       tbl[i].fuel);
            chk("tbl_te",   thrust_eff, tbl[i].te);
        end

        // tick while busy is ignored: exactly one step runs
        start_step(16'h0003);
        repeat (4) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_done(lat);
        model_step(16'h0003);
        check_model("busy_tick");
        count_done(30, nd);
        chk("busy_tick_extra_done", nd, 0);
        chk("busy_tick_idle", {31'd0, busy}, 32'd0);

        // tick with wen=0 never starts a step
        s_alt = alt; s_vel = vel; s_fuel = fuel; s_te = thrust_eff;
        @(negedge clk);
        tick = 1'b1; wen = 1'b0;
        @(negedge clk);
        tick = 1'b0;
        chk("wen0_busy", {31'd0, busy}, 32'd0);
        count_done(25, nd);
        chk("wen0_done", nd, 0);
        chk("wen0_alt", alt, s_alt);
        wen = 1'b1;

        // wen dropped before COMMIT discards the step
        start_step(16'h0004);
        repeat (8) @(negedge clk);
        wen = 1'b0;
        count_done(30, nd);
        chk("wendrop_done", nd, 0);
        chk("wendrop_busy", {31'd0, busy}, 32'd0);
        chk("wendrop_alt",  alt,  s_alt);
        chk("wendrop_vel",  vel,  s_vel);
        chk("wendrop_fuel", fuel, s_fuel);
        chk("wendrop_te",   thrust_eff, s_te);
        wen = 1'b1;

        // randomized steps from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            t = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (i % 3 == 0) t[15:12] = 4'($urandom_range(0, 1));
            run_step(t);
            check_model("rand");
        end

        // reset at cycle 9 of a step aborts it
        start_step(16'h0100);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_alt",  alt,  16'h4500);
        chk("midrst_vel",  vel,  16'h0000);
        chk("midrst_fuel", fuel, 16'h0800);
        chk("midrst_te",   thrust_eff, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        count_done(25, nd);
        chk("midrst_no_done", nd, 0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        model_reset();

        // descend to vel=5002, then one more step probes the overflow path
        run_step(16'h0002);
        for (int i = 0; i < 999; i++) run_step(16'h0000);
        check_model("descent");
        chk("descent_vel", vel, 16'h5002);
`ifdef LL_VEL_SAT_EN
        exp6 = 16'h5000;
`else
        exp6 = 16'h4997;
`endif
        run_step(16'h0000);
        chk("ovf_vel", vel, exp6);
        check_model("ovf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
